// File: rtl/fp_timer_core.sv
// Prescaled free-running timer with compare/match flag and a CNT_LO/CNT_HI shadow on the FPRO slot bus.
// Register writes take effect at the next clk edge; reads are combinational with no wait states and no backpressure.
module fp_timer_core #(
    parameter int CNT_W = 48
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        irq
);

    localparam logic [4:0] A_CNT_LO = 5'd0;
    localparam logic [4:0] A_CNT_HI = 5'd1;
    localparam logic [4:0] A_CTRL   = 5'd2;
    localparam logic [4:0] A_CMP_LO = 5'd3;
    localparam logic [4:0] A_CMP_HI = 5'd4;
    localparam logic [4:0] A_STATUS = 5'd5;
    localparam logic [4:0] A_PRESC  = 5'd6;

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [15:0]      presc_cnt_q, presc_cnt_d;
    logic [15:0]      presc_q, presc_d;
    logic [31:0]      shadow_q, shadow_d;
    logic             go_q, go_d;
    logic             auto_reload_q, auto_reload_d;
    logic             irq_en_q, irq_en_d;
    logic             flag_q, flag_d;

    logic wr_en, rd_en, ctrl_wr, clr, tick, hit, match;

    always_comb begin
        wr_en   = cs & write;
        rd_en   = cs & read;
        ctrl_wr = wr_en && (addr == A_CTRL);
        clr     = ctrl_wr && wr_data[1];
        tick    = go_q && (presc_cnt_q == presc_q);
        hit     = (count_q == cmp_q);
        match   = tick && hit;

        // Clear beats a coincident tick; the tick still reports a match below.
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (tick) begin
            count_d = (auto_reload_q && hit) ? '0 : count_q + CNT_W'(1);
        end

        presc_cnt_d = presc_cnt_q;
        if (clr) begin
            presc_cnt_d = '0;
        end else if (go_q) begin
            presc_cnt_d = tick ? 16'd0 : presc_cnt_q + 16'd1;
        end

        go_d          = go_q;
        auto_reload_d = auto_reload_q;
        irq_en_d      = irq_en_q;
        if (ctrl_wr) begin
            go_d          = wr_data[0];
            auto_reload_d = wr_data[2];
            irq_en_d      = wr_data[3];
        end

        cmp_d = cmp_q;
        if (wr_en && (addr == A_CMP_LO)) begin
            cmp_d[31:0] = wr_data;
        end
        if (wr_en && (addr == A_CMP_HI)) begin
            cmp_d[CNT_W-1:32] = wr_data[CNT_W-33:0];
        end

        presc_d = presc_q;
        if (wr_en && (addr == A_PRESC)) begin
            presc_d = wr_data[15:0];
        end

        // A match in the same cycle as a W1C keeps the flag set.
        flag_d = flag_q;
        if (match) begin
            flag_d = 1'b1;
        end else if (wr_en && (addr == A_STATUS) && wr_data[0]) begin
            flag_d = 1'b0;
        end

        shadow_d = shadow_q;
        if (rd_en && (addr == A_CNT_LO)) begin
            shadow_d = 32'(count_q >> 32);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q       <= '0;
            cmp_q         <= '0;
            presc_cnt_q   <= '0;
            presc_q       <= '0;
            shadow_q      <= '0;
            go_q          <= 1'b0;
            auto_reload_q <= 1'b0;
            irq_en_q      <= 1'b0;
            flag_q        <= 1'b0;
        end else begin
            count_q       <= count_d;
            cmp_q         <= cmp_d;
            presc_cnt_q   <= presc_cnt_d;
            presc_q       <= presc_d;
            shadow_q      <= shadow_d;
            go_q          <= go_d;
            auto_reload_q <= auto_reload_d;
            irq_en_q      <= irq_en_d;
            flag_q        <= flag_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (cs) begin
            case (addr)
                A_CNT_LO: rd_data = count_q[31:0];
                A_CNT_HI: rd_data = shadow_q;
                A_CTRL:   rd_data = {28'd0, irq_en_q, auto_reload_q, 1'b0, go_q};
                A_CMP_LO: rd_data = cmp_q[31:0];
                A_CMP_HI: rd_data = 32'(cmp_q >> 32);
                A_STATUS: rd_data = {31'd0, flag_q};
                A_PRESC:  rd_data = {16'd0, presc_q};
                default:  rd_data = '0;
            endcase
        end
    end

    assign irq = flag_q & irq_en_q;

endmodule
